// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_pkg
//  Purpose  : Shared state encoding, byte width and index helper for the
//             UART TX arbiter and its round-robin picker.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int UART_DATA_SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_START       = 3'd1,
        ST_WAIT_ACCEPT = 3'd2,
        ST_WAIT_DONE   = 3'd3,
        ST_HOLD        = 3'd4
    } arb_state_t;

    // (base + offset) modulo n, for base < n and offset < n
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + offset;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_select
//  Purpose  : Combinational round-robin picker: first set request at or
//             above the pointer (with wrap) -> one-hot grant and index.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 3,
    parameter int IDX_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] i_req,
    input  logic [IDX_W-1:0]          i_ptr,
    output logic [NUM_REQUESTERS-1:0] o_grant,
    output logic [IDX_W-1:0]          o_idx,
    output logic                      o_valid
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            w_cand = IDX_W'(wrap_add(32'(i_ptr), 32'(i), 32'(NUM_REQUESTERS)));
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin, frame-locked sharing of one UART TX core among
//             several byte-stream requesters. Optional HOLD watchdog is
//             built when UART_ARB_WATCHDOG_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 3,
    parameter int UART_DATA_SIZE = uart_tx_arbiter_pkg::UART_DATA_SIZE,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic                                 i_clock,
    input  logic                                 i_nReset,
    input  logic [NUM_REQUESTERS-1:0]            i_req,
    input  logic [NUM_REQUESTERS*UART_DATA_SIZE-1:0] i_data,
    input  logic [NUM_REQUESTERS-1:0]            i_last,
    output logic [NUM_REQUESTERS-1:0]            o_ack,
    output logic [NUM_REQUESTERS-1:0]            o_grant,
    output logic                                 o_txStart,
    output logic [UART_DATA_SIZE-1:0]            o_txData,
    input  logic                                 i_txBusy,
    output logic                                 o_busy,
    output logic                                 o_timeout
);

    localparam int c_IDX_W = $clog2(NUM_REQUESTERS);

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    logic [c_IDX_W-1:0]        r_ptr;
    logic [c_IDX_W-1:0]        r_owner;
    logic [c_IDX_W-1:0]        w_pick_idx;
    logic [c_IDX_W-1:0]        w_sel;
    logic [NUM_REQUESTERS-1:0] w_pick_grant;
    logic [NUM_REQUESTERS-1:0] w_sel_onehot;
    logic [NUM_REQUESTERS-1:0] r_grant;
    logic [NUM_REQUESTERS-1:0] r_ack;
    logic                      w_pick_valid;
    logic                      w_load;
    logic                      w_frame_done;
    logic                      w_timeout_fire;
    logic                      w_release;
    logic                      w_wdog_expired;
    logic                      r_tx_start;
    logic                      r_last;
    logic [UART_DATA_SIZE-1:0] r_tx_data;
    logic [UART_DATA_SIZE-1:0] w_sel_byte;
    logic                      w_sel_last;

    rr_priority_select #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .IDX_W          (c_IDX_W)
    ) u_rr_select (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // In IDLE the picker chooses; afterwards only the frame owner is looked at
    assign w_sel        = (r_state == ST_IDLE) ? w_pick_idx : r_owner;
    assign w_sel_byte   = i_data[w_sel*UART_DATA_SIZE +: UART_DATA_SIZE];
    assign w_sel_last   = i_last[w_sel];
    assign w_sel_onehot = (r_state == ST_IDLE) ? w_pick_grant
                                               : (NUM_REQUESTERS'(1) << r_owner);
    assign w_release    = w_frame_done | w_timeout_fire;

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_frame_done   = 1'b0;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_load       = 1'b1;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (i_txBusy) begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_txBusy) begin
                    if (r_last) begin
                        w_frame_done = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A byte arriving on the expiry cycle is still served
                if (i_req[r_owner]) begin
                    w_load       = 1'b1;
                    w_next_state = ST_START;
                end else if (w_wdog_expired) begin
                    w_timeout_fire = 1'b1;
                    w_next_state   = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_last     <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            if (w_load) begin
                r_tx_data  <= w_sel_byte;
                r_last     <= w_sel_last;
                r_ack      <= w_sel_onehot;
                r_tx_start <= 1'b1;
                r_owner    <= w_sel;
                r_grant    <= w_sel_onehot;
            end
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= c_IDX_W'(wrap_add(32'(r_owner), 32'd1, 32'(NUM_REQUESTERS)));
            end
        end
    end

`ifdef UART_ARB_WATCHDOG_EN
    localparam int c_WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_WDOG_W-1:0] r_hold_cnt;
    logic                r_timeout;

    // Counter idles at zero outside HOLD, so it reads zero on the entry cycle
    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_fire;
            if (r_state != ST_HOLD) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign w_wdog_expired = (r_hold_cnt == c_WDOG_W'(TIMEOUT_CYCLES - 1));
    assign o_timeout      = r_timeout;
`else
    assign w_wdog_expired = 1'b0;
    assign o_timeout      = 1'b0;
`endif

    assign o_ack     = r_ack;
    assign o_grant   = r_grant;
    assign o_txStart = r_tx_start;
    assign o_txData  = r_tx_data;
    assign o_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        i_clock = 1'b0;
    logic        i_nReset;
    logic [2:0]  i_req;
    logic [23:0] i_data;
    logic [2:0]  i_last;
    logic        i_txBusy;
    logic [2:0]  o_ack;
    logic [2:0]  o_grant;
    logic        o_txStart;
    logic [7:0]  o_txData;
    logic        o_busy;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  req;
        logic [23:0] data;
        int          exp_idx;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [15];

    uart_tx_arbiter #(
        .NUM_REQUESTERS (3),
        .UART_DATA_SIZE (8),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clock   (i_clock),
        .i_nReset  (i_nReset),
        .i_req     (i_req),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_ack     (o_ack),
        .o_grant   (o_grant),
        .o_txStart (o_txStart),
        .o_txData  (o_txData),
        .i_txBusy  (i_txBusy),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One byte transfer: present request, expect ack/start one cycle later,
    // then play the UART core (busy for busy_cycles). reset_at >= 0 pulls
    // reset low in that busy cycle instead of finishing the byte.
    task automatic do_byte(input string tag, input logic [2:0] req, input logic [23:0] data,
                           input logic [2:0] last, input logic [2:0] keep, input int exp_idx,
                           input logic [7:0] exp_byte, input int busy_cycles, input int reset_at);
        bit         got;
        int         lat;
        logic [2:0] exp_oh;
        exp_oh = 3'b001 << exp_idx;
        got    = 1'b0;
        lat    = 0;
        @(posedge i_clock); #1;
        i_req  = req;
        i_data = data;
        i_last = last;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clock);
            if (o_ack != 3'b000) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
        check($sformatf("%s ack_seen", tag), 32'(got), 32'd1);
        if (!got) return;
        check($sformatf("%s latency", tag), 32'(lat), 32'd1);
        check($sformatf("%s ack", tag), 32'(o_ack), 32'(exp_oh));
        check($sformatf("%s txStart", tag), 32'(o_txStart), 32'd1);
        check($sformatf("%s txData", tag), 32'(o_txData), 32'(exp_byte));
        check($sformatf("%s grant", tag), 32'(o_grant), 32'(exp_oh));
        check($sformatf("%s busy_timeout", tag), 32'({o_busy, o_timeout}), 32'b10);
        @(posedge i_clock); #1;
        i_req    = req & keep;
        i_txBusy = 1'b1;
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge i_clock);
            check($sformatf("%s hold_%0d", tag, i), 32'({o_ack, o_txStart, o_txData, o_grant}),
                  32'({3'b000, 1'b0, exp_byte, exp_oh}));
            if (i == reset_at) begin
                #1 i_nReset = 1'b0;
                #1;
                check($sformatf("%s async_reset", tag),
                      32'({o_ack, o_grant, o_txStart, o_txData, o_busy, o_timeout}), 32'd0);
                i_txBusy = 1'b0;
                i_req    = 3'b000;
                return;
            end
        end
        @(posedge i_clock); #1;
        i_txBusy = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clock);
            if (!o_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check($sformatf("%s idle_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s idle_grant", tag), 32'(o_grant), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: actual=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        i_nReset = 1'b0;
        i_req    = 3'b000;
        i_data   = 24'h0;
        i_last   = 3'b000;
        i_txBusy = 1'b0;

        vecs[0]  = '{3'b001, 24'h000041, 0, 8'h41};
        vecs[1]  = '{3'b111, 24'hC3B2A1, 1, 8'hB2};
        vecs[2]  = '{3'b111, 24'hC3B2A1, 2, 8'hC3};
        vecs[3]  = '{3'b111, 24'hC3B2A1, 0, 8'hA1};
        vecs[4]  = '{3'b111, 24'hC3B2A1, 1, 8'hB2};
        vecs[5]  = '{3'b111, 24'hC3B2A1, 2, 8'hC3};
        vecs[6]  = '{3'b010, 24'hC3B2A1, 1, 8'hB2};
        vecs[7]  = '{3'b001, 24'hC3B2A1, 0, 8'hA1};
        vecs[8]  = '{3'b100, 24'hC3B2A1, 2, 8'hC3};
        vecs[9]  = '{3'b110, 24'hC3B2A1, 1, 8'hB2};
        vecs[10] = '{3'b011, 24'hC3B2A1, 0, 8'hA1};
        vecs[11] = '{3'b101, 24'hC3B2A1, 2, 8'hC3};
        vecs[12] = '{3'b001, 24'hC3B2A1, 0, 8'hA1};
        vecs[13] = '{3'b001, 24'hC3B2A1, 0, 8'hA1};
        vecs[14] = '{3'b100, 24'hC3B2A1, 2, 8'hC3};

        repeat (3) @(negedge i_clock);
        check("reset_outputs", 32'({o_ack, o_grant, o_txStart, o_txData, o_busy, o_timeout}), 32'd0);
        @(posedge i_clock); #1;
        i_nReset = 1'b1;

        // Single-byte frames: single byte, fairness, wrap and repeat grants
        for (int r = 0; r < 15; r++) begin
            do_byte($sformatf("vec%0d", r), vecs[r].req, vecs[r].data, 3'b111, 3'b000,
                    vecs[r].exp_idx, vecs[r].exp_byte, (r == 0) ? 10 : 3, -1);
            wait_idle($sformatf("vec%0d", r));
        end

        // Frame lock: requester 1 waits through 0's three-byte frame
        do_byte("lockAA", 3'b011, 24'h0055AA, 3'b010, 3'b010, 0, 8'hAA, 3, -1);
        do_byte("lockBB", 3'b011, 24'h0055BB, 3'b010, 3'b010, 0, 8'hBB, 3, -1);
        do_byte("lockCC", 3'b011, 24'h0055CC, 3'b011, 3'b010, 0, 8'hCC, 3, -1);
        do_byte("lock55", 3'b010, 24'h0055CC, 3'b011, 3'b000, 1, 8'h55, 3, -1);
        wait_idle("lock55");

        // Reset during WAIT_DONE of the second byte of a frame
        do_byte("rstB1", 3'b001, 24'h000011, 3'b000, 3'b000, 0, 8'h11, 3, -1);
        do_byte("rstB2", 3'b001, 24'h000022, 3'b000, 3'b000, 0, 8'h22, 4, 2);
        repeat (2) @(negedge i_clock);
        check("rst_held", 32'({o_ack, o_grant, o_txStart, o_txData, o_busy, o_timeout}), 32'd0);
        @(posedge i_clock); #1;
        i_nReset = 1'b1;
        do_byte("rstNew", 3'b110, 24'hC3B200, 3'b111, 3'b000, 1, 8'hB2, 3, -1);
        wait_idle("rstNew");
        do_byte("rstTail", 3'b101, 24'hC3B2A1, 3'b111, 3'b000, 2, 8'hC3, 3, -1);
        wait_idle("rstTail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
